// File: rtl/alu_pkg.sv
// Opcode encodings and legality check shared by the ALU core and execute stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  function automatic logic alu_is_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_NOR, ALU_SLT: alu_is_legal = 1'b1;
      default:                   alu_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream operand handshake and downstream result handshake of the execute stage.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ovf;
  logic             out_err;

  // The stage itself
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_err
  );

  // Upstream producer plus downstream consumer
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_err
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: add/sub with signed overflow, logic ops, signed set-less-than.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             err
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    err    = ~alu_is_legal(op);
    case (op)
      ALU_ADD: begin
        result = sum;
        ovf    = add_ovf;
      end
      ALU_SUB: begin
        result = diff;
        ovf    = sub_ovf;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      // Overflow flips the apparent sign of the difference
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: one-entry output register behind a valid/ready handshake.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_exec_stage_if.slave    bus,
  output logic [CNT_W-1:0]   op_count
);

  logic [WIDTH-1:0] core_result;
  logic             core_ovf;
  logic             core_err;
  logic             in_fire;
  logic             out_fire;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (bus.in_op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .result (core_result),
    .ovf    (core_ovf),
    .err    (core_err)
  );

  // Bubble-free: a held result that leaves this cycle frees the slot
  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_zero   <= 1'b0;
      bus.out_ovf    <= 1'b0;
      bus.out_err    <= 1'b0;
      op_count       <= '0;
    end else begin
      if (in_fire) begin
        bus.out_valid  <= 1'b1;
        bus.out_result <= core_result;
        bus.out_zero   <= (core_result == '0);
        bus.out_ovf    <= core_ovf;
        bus.out_err    <= core_err;
      end else if (out_fire) begin
        bus.out_valid  <= 1'b0;
      end
      if (out_fire) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, scoreboard on out_fire, corner sequences.
module tb_alu_exec_stage;

  localparam int W = 32;
  localparam int C = 16;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         o;
    logic         e;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    logic         e;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [C-1:0] op_count;
  int           checks;
  int           errors;
  exp_t         sb[$];

  alu_exec_stage_if #(.WIDTH(W)) bus ();

  alu_exec_stage #(.WIDTH(W), .CNT_W(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: widened signed arithmetic and native signed compare
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         x;
    logic [W:0]   s;
    x = '{r: '0, z: 1'b0, o: 1'b0, e: 1'b0};
    case (op)
      4'b0000: begin s = {a[W-1], a} + {b[W-1], b}; x.r = s[W-1:0]; x.o = s[W] != s[W-1]; end
      4'b0010: begin s = {a[W-1], a} - {b[W-1], b}; x.r = s[W-1:0]; x.o = s[W] != s[W-1]; end
      4'b0100: x.r = a & b;
      4'b0101: x.r = a | b;
      4'b0110: x.r = a ^ b;
      4'b0111: x.r = ~(a | b);
      4'b1010: x.r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == '0);
    return x;
  endfunction

  // Scoreboard: every accepted result must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_fire", 64'(bus.out_result), 64'hDEAD);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_result", 64'(bus.out_result), 64'(x.r));
        check("sb_zero",   64'(bus.out_zero),   64'(x.z));
        check("sb_ovf",    64'(bus.out_ovf),    64'(x.o));
        check("sb_err",    64'(bus.out_err),    64'(x.e));
      end
    end
  end

  task automatic set_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[11];
  logic [3:0] legal_ops[7];

  initial begin
    exp_t x;
    checks = 0;
    errors = 0;
    legal_ops = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010};
    vecs[0]  = '{4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b1010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b1010, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'b0010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b0110, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'b1111, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{4'b0001, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_op     = 4'b0000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  64'(bus.out_valid),  64'h0);
    check("rst_in_ready",   64'(bus.in_ready),   64'h1);
    check("rst_op_count",   64'(op_count),       64'h0);
    check("rst_out_result", 64'(bus.out_result), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed table, back to back with out_ready high
    for (int i = 0; i < 11; i++) begin
      set_op(vecs[i].op, vecs[i].a, vecs[i].b);
      sb.push_back('{r: vecs[i].r, z: vecs[i].z, o: vecs[i].o, e: vecs[i].e});
      @(negedge clk);
      check("tbl_in_ready", 64'(bus.in_ready), 64'h1);
      @(posedge clk);
      #1 check("tbl_latency_valid", 64'(bus.out_valid), 64'h1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 check("tbl_op_count", 64'(op_count), 64'd11);
    check("tbl_drained", 64'(bus.out_valid), 64'h0);

    // Backpressure with a queued op, then same-cycle swap
    do_reset();
    bus.out_ready = 1'b0;
    set_op(4'b0100, 32'h0000F0F0, 32'h00000FF0);
    sb.push_back('{r: 32'h000000F0, z: 1'b0, o: 1'b0, e: 1'b0});
    @(posedge clk);
    #1 set_op(4'b0101, 32'h0000F0F0, 32'h00000FF0);
    sb.push_back('{r: 32'h0000FFF0, z: 1'b0, o: 1'b0, e: 1'b0});
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_result", 64'(bus.out_result), 64'h00F0);
      check("bp_hold_valid",  64'(bus.out_valid),  64'h1);
      check("bp_in_ready",    64'(bus.in_ready),   64'h0);
      check("bp_no_count",    64'(op_count),       64'h0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("swap_in_ready", 64'(bus.in_ready), 64'h1);
    @(posedge clk);
    #1 check("swap_valid", 64'(bus.out_valid),  64'h1);
    check("swap_result",   64'(bus.out_result), 64'hFFF0);
    check("swap_op_count", 64'(op_count),       64'h1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 check("swap_drain_count", 64'(op_count), 64'h2);
    check("swap_drain_valid", 64'(bus.out_valid), 64'h0);

    // Stream of 8 model-checked ops at one per cycle
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = legal_ops[$urandom_range(0, 6)];
      a  = (i % 3 == 0) ? 32'h80000000 : W'($urandom);
      b  = (i % 4 == 1) ? 32'h7FFFFFFF : W'($urandom);
      set_op(op, a, b);
      x = model(op, a, b);
      sb.push_back(x);
      @(posedge clk);
      #1 check("stream_valid", 64'(bus.out_valid), 64'h1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 check("stream_op_count", 64'(op_count), 64'd8);
    check("stream_drained", 64'(bus.out_valid), 64'h0);

    // Reset while a result is held under backpressure
    bus.out_ready = 1'b0;
    set_op(4'b0000, 32'h1, 32'h2);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("hold_before_reset", 64'(bus.out_valid), 64'h1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_valid",    64'(bus.out_valid), 64'h0);
    check("midrst_op_count", 64'(op_count),      64'h0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("midrst_no_fire", 64'(op_count), 64'h0);

    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
